// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD up/down timer with IDLE/RUN/PAUSE/DONE sequencing, preset load,
// terminal-count stop or auto-reload, and 7-segment decode for both digits.
module bcd_timer_ctrl #(
    parameter int unsigned LIMIT_TENS  = 5,
    parameter int unsigned LIMIT_ONES  = 9,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic       clk1Hz,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic       up_down,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    output logic [3:0] tens_out,
    output logic [3:0] ones_out,
    output logic [1:0] state_out,
    output logic       done,
    output logic       wrap,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [3:0] LIM_T = 4'(LIMIT_TENS);
    localparam logic [3:0] LIM_O = 4'(LIMIT_ONES);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       wrap_q, wrap_d;

    logic [3:0] pre_t, pre_o;
    logic       pre_over;
    logic       at_term;

    // Digit clamps first; with both digits in 0-9 a lexicographic compare equals a value compare.
    always_comb begin
        pre_t    = (preset_tens > 4'd9) ? 4'd9 : preset_tens;
        pre_o    = (preset_ones > 4'd9) ? 4'd9 : preset_ones;
        pre_over = (pre_t > LIM_T) || ((pre_t == LIM_T) && (pre_o > LIM_O));
        at_term  = up_down ? ((tens_q == LIM_T) && (ones_q == LIM_O))
                           : ((tens_q == '0) && (ones_q == '0));
    end

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        wrap_d  = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            tens_d  = '0;
            ones_d  = '0;
        end else if (load && (state_q != ST_RUN)) begin
            state_d = (state_q == ST_PAUSE) ? ST_PAUSE : ST_IDLE;
            tens_d  = pre_over ? LIM_T : pre_t;
            ones_d  = pre_over ? LIM_O : pre_o;
        end else if (stop && (state_q == ST_RUN)) begin
            state_d = ST_PAUSE;
        end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSE))) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (at_term) begin
                if (AUTO_RELOAD) begin
                    wrap_d = 1'b1;
                    tens_d = up_down ? 4'd0 : LIM_T;
                    ones_d = up_down ? 4'd0 : LIM_O;
                end else begin
                    state_d = ST_DONE;
                end
            end else if (up_down) begin
                if (ones_q == 4'd9) begin
                    ones_d = '0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk1Hz or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tens_q  <= '0;
            ones_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            wrap_q  <= wrap_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1110011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    assign tens_out  = tens_q;
    assign ones_out  = ones_q;
    assign state_out = state_q;
    assign done      = (state_q == ST_DONE);
    assign wrap      = wrap_q;
    assign seg_tens  = seg7(tens_q);
    assign seg_ones  = seg7(ones_q);

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: one instance per AUTO_RELOAD setting, both compared
// every edge against an integer-valued model of the timer.
module tb_bcd_timer_ctrl;

    localparam int LIMIT = 59;

    logic       clk1Hz = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic       up_down = 1'b1;
    logic [3:0] preset_tens = 4'd0, preset_ones = 4'd0;

    logic [3:0] tens_out [2];
    logic [3:0] ones_out [2];
    logic [1:0] state_out [2];
    logic       done_o [2];
    logic       wrap_o [2];
    logic [6:0] seg_tens [2];
    logic [6:0] seg_ones [2];
    logic [25:0] obs [2];

    int checks = 0;
    int failures = 0;

    // model: value as a plain integer, state 0=IDLE 1=RUN 2=PAUSE 3=DONE
    int mval [2];
    int mst [2];
    bit mwrap [2];
    int lt, lo, lv;

    bcd_timer_ctrl #(.LIMIT_TENS(5), .LIMIT_ONES(9), .AUTO_RELOAD(1'b0)) dut_stop (
        .clk1Hz(clk1Hz), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .load(load), .up_down(up_down), .preset_tens(preset_tens), .preset_ones(preset_ones),
        .tens_out(tens_out[0]), .ones_out(ones_out[0]), .state_out(state_out[0]),
        .done(done_o[0]), .wrap(wrap_o[0]), .seg_tens(seg_tens[0]), .seg_ones(seg_ones[0])
    );

    bcd_timer_ctrl #(.LIMIT_TENS(5), .LIMIT_ONES(9), .AUTO_RELOAD(1'b1)) dut_wrap (
        .clk1Hz(clk1Hz), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .load(load), .up_down(up_down), .preset_tens(preset_tens), .preset_ones(preset_ones),
        .tens_out(tens_out[1]), .ones_out(ones_out[1]), .state_out(state_out[1]),
        .done(done_o[1]), .wrap(wrap_o[1]), .seg_tens(seg_tens[1]), .seg_ones(seg_ones[1])
    );

    assign obs[0] = {tens_out[0], ones_out[0], state_out[0], done_o[0], wrap_o[0], seg_tens[0], seg_ones[0]};
    assign obs[1] = {tens_out[1], ones_out[1], state_out[1], done_o[1], wrap_o[1], seg_tens[1], seg_ones[1]};

    always #5 clk1Hz = ~clk1Hz;

    always @(posedge clk1Hz or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                mval[k] = 0; mst[k] = 0; mwrap[k] = 1'b0;
            end else begin
                mwrap[k] = 1'b0;
                if (clear) begin
                    mval[k] = 0; mst[k] = 0;
                end else if (load && mst[k] != 1) begin
                    lt = (int'(preset_tens) > 9) ? 9 : int'(preset_tens);
                    lo = (int'(preset_ones) > 9) ? 9 : int'(preset_ones);
                    lv = lt * 10 + lo;
                    mval[k] = (lv > LIMIT) ? LIMIT : lv;
                    mst[k] = (mst[k] == 2) ? 2 : 0;
                end else if (stop && mst[k] == 1) begin
                    mst[k] = 2;
                end else if (start && (mst[k] == 0 || mst[k] == 2)) begin
                    mst[k] = 1;
                end else if (mst[k] == 1) begin
                    if (up_down) begin
                        if (mval[k] == LIMIT) begin
                            if (k == 1) begin mval[k] = 0; mwrap[k] = 1'b1; end
                            else mst[k] = 3;
                        end else mval[k] = mval[k] + 1;
                    end else begin
                        if (mval[k] == 0) begin
                            if (k == 1) begin mval[k] = LIMIT; mwrap[k] = 1'b1; end
                            else mst[k] = 3;
                        end else mval[k] = mval[k] - 1;
                    end
                end
            end
        end
    end

    function automatic logic [6:0] segm(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1110011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [25:0] expv(input int k);
        int v;
        v = mval[k];
        return {4'(v / 10), 4'(v % 10), 2'(mst[k]), (mst[k] == 3), mwrap[k], segm(v / 10), segm(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk1Hz);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                failures++;
                $display("FAIL reset dut%0d got=%h exp=%h", k, obs[k], expv(k));
            end
        end
        checks++;
        if (seg_ones[0] !== 7'b1111110 || state_out[0] !== 2'b00) begin
            failures++;
            $display("FAIL reset_const got seg=%b state=%b exp seg=1111110 state=00", seg_ones[0], state_out[0]);
        end
        reset = 1'b1;
    endtask

    task automatic test_count_up();
        up_down = 1'b1;
        start = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            tick();
            start = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    failures++;
                    $display("FAIL count_up dut%0d edge%0d got=%h exp=%h", k, i, obs[k], expv(k));
                end
            end
        end
        checks++;
        if (tens_out[0] !== 4'd1 || ones_out[0] !== 4'd0 || seg_ones[0] !== 7'b1111110 || seg_tens[0] !== 7'b0110000) begin
            failures++;
            $display("FAIL count_up_10 got=%h%h seg=%b/%b exp=10 seg=0110000/1111110",
                     tens_out[0], ones_out[0], seg_tens[0], seg_ones[0]);
        end
    endtask

    task automatic test_done();
        clear = 1'b1; tick(); clear = 1'b0;
        load = 1'b1; preset_tens = 4'd5; preset_ones = 4'd7; tick(); load = 1'b0;
        up_down = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) start = 1'b1;
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    failures++;
                    $display("FAIL done dut%0d edge%0d got=%h exp=%h", k, i, obs[k], expv(k));
                end
            end
            if (i >= 2) begin
                checks++;
                if (done_o[0] !== 1'b1 || state_out[0] !== 2'b11 || tens_out[0] !== 4'd5 || ones_out[0] !== 4'd9) begin
                    failures++;
                    $display("FAIL done_hold edge%0d got done=%b state=%b val=%h%h exp done=1 state=11 val=59",
                             i, done_o[0], state_out[0], tens_out[0], ones_out[0]);
                end
            end
        end
        start = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if (state_out[0] !== 2'b00 || tens_out[0] !== 4'd0 || ones_out[0] !== 4'd0 || done_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL done_clear got state=%b val=%h%h exp state=00 val=00", state_out[0], tens_out[0], ones_out[0]);
        end
    endtask

    task automatic test_wrap();
        load = 1'b1; preset_tens = 4'd0; preset_ones = 4'd2; tick(); load = 1'b0;
        up_down = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    failures++;
                    $display("FAIL wrap dut%0d edge%0d got=%h exp=%h", k, i, obs[k], expv(k));
                end
            end
            if (i == 3) begin
                checks++;
                if (wrap_o[1] !== 1'b1 || state_out[1] !== 2'b01 || tens_out[1] !== 4'd5 || ones_out[1] !== 4'd9) begin
                    failures++;
                    $display("FAIL wrap_pulse got wrap=%b state=%b val=%h%h exp wrap=1 state=01 val=59",
                             wrap_o[1], state_out[1], tens_out[1], ones_out[1]);
                end
            end
            if (i == 4) begin
                checks++;
                if (wrap_o[1] !== 1'b0 || ones_out[1] !== 4'd8) begin
                    failures++;
                    $display("FAIL wrap_clear got wrap=%b ones=%h exp wrap=0 ones=8", wrap_o[1], ones_out[1]);
                end
            end
        end
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_load_clamp();
        load = 1'b1; preset_tens = 4'd7; preset_ones = 4'hA; tick();
        checks++;
        if (tens_out[0] !== 4'd5 || ones_out[0] !== 4'd9 || state_out[0] !== 2'b00) begin
            failures++;
            $display("FAIL clamp_7A got=%h%h state=%b exp=59 state=00", tens_out[0], ones_out[0], state_out[0]);
        end
        preset_tens = 4'd3; preset_ones = 4'hF; tick(); load = 1'b0;
        checks++;
        if (tens_out[1] !== 4'd3 || ones_out[1] !== 4'd9) begin
            failures++;
            $display("FAIL clamp_3F got=%h%h exp=39", tens_out[1], ones_out[1]);
        end
        up_down = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        load = 1'b1; preset_tens = 4'd1; preset_ones = 4'd2;
        for (int i = 0; i < 2; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    failures++;
                    $display("FAIL load_run dut%0d edge%0d got=%h exp=%h", k, i, obs[k], expv(k));
                end
            end
        end
        load = 1'b0;
        checks++;
        if (tens_out[0] !== 4'd4 || ones_out[0] !== 4'd1 || state_out[0] !== 2'b01) begin
            failures++;
            $display("FAIL load_in_run got=%h%h state=%b exp=41 state=01", tens_out[0], ones_out[0], state_out[0]);
        end
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_pause();
        // per edge: {load, start, stop}
        logic [2:0] seq [7];
        seq[0] = 3'b100; seq[1] = 3'b010; seq[2] = 3'b000; seq[3] = 3'b001;
        seq[4] = 3'b000; seq[5] = 3'b010; seq[6] = 3'b000;
        preset_tens = 4'd2; preset_ones = 4'd2; up_down = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 7) {load, start, stop} = seq[i];
            else {load, start, stop} = (i == 7) ? 3'b000 : 3'b011;
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    failures++;
                    $display("FAIL pause dut%0d edge%0d got=%h exp=%h", k, i, obs[k], expv(k));
                end
            end
            if (i == 4 || i == 8) begin
                checks++;
                if (state_out[0] !== 2'b10 || ones_out[0] !== ((i == 4) ? 4'd3 : 4'd5)) begin
                    failures++;
                    $display("FAIL pause_hold edge%0d got state=%b ones=%h exp state=10 ones=%0d",
                             i, state_out[0], ones_out[0], (i == 4) ? 3 : 5);
                end
            end
            if (i == 5) begin
                checks++;
                if (state_out[0] !== 2'b01 || ones_out[0] !== 4'd3) begin
                    failures++;
                    $display("FAIL resume_latency got state=%b ones=%h exp state=01 ones=3", state_out[0], ones_out[0]);
                end
            end
        end
        {load, start, stop} = 3'b000;
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; preset_tens = 4'd4; preset_ones = 4'd0; tick(); load = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                failures++;
                $display("FAIL async_reset dut%0d got=%h exp=%h", k, obs[k], expv(k));
            end
        end
        checks++;
        if (tens_out[0] !== 4'd0 || ones_out[0] !== 4'd0 || state_out[0] !== 2'b00 || done_o[0] !== 1'b0 || wrap_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_const got val=%h%h state=%b exp val=00 state=00",
                     tens_out[0], ones_out[0], state_out[0]);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin clear = 1'b1; load = 1'b1; preset_tens = 4'd3; preset_ones = 4'd3; end
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    failures++;
                    $display("FAIL post_reset dut%0d edge%0d got=%h exp=%h", k, i, obs[k], expv(k));
                end
            end
        end
        checks++;
        if (tens_out[1] !== 4'd0 || ones_out[1] !== 4'd0) begin
            failures++;
            $display("FAIL clear_over_load got=%h%h exp=00", tens_out[1], ones_out[1]);
        end
        clear = 1'b0; load = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            clear = ($urandom_range(0, 39) == 0);
            load  = ($urandom_range(0, 11) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) up_down = ~up_down;
            preset_tens = 4'($urandom_range(0, 15));
            preset_ones = 4'($urandom_range(0, 15));
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    failures++;
                    $display("FAIL random dut%0d iter%0d got=%h exp=%h", k, i, obs[k], expv(k));
                end
            end
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b0;
                #1;
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (obs[k] !== expv(k)) begin
                        failures++;
                        $display("FAIL random_reset dut%0d iter%0d got=%h exp=%h", k, i, obs[k], expv(k));
                    end
                end
                reset = 1'b1;
            end
        end
        {clear, load, stop, start} = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_done();
        test_wrap();
        test_load_clamp();
        test_pause();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
